// File: rtl/kaktovik_pkg.sv
// rtl/kaktovik_pkg.sv - shared constants, state enum and helpers for the Kaktovik scanner
package kaktovik_pkg;

  localparam int BASE = 20;
  localparam int DIGIT_W = 5;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    STORE
  } state_t;

  // BASE**n as a 64-bit constant, used for the overflow threshold
  function automatic logic [63:0] pow_base(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'(BASE);
    return r;
  endfunction

endpackage

// File: rtl/kaktovik_div20.sv
// rtl/kaktovik_div20.sv - restoring divide-by-20 step datapath (work, rem, quotient)
module kaktovik_div20
  import kaktovik_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   din,
  input  logic               step,
  input  logic               clr_rem,
  output logic [DIGIT_W-1:0] rem
);

  // Quotient bits shift into the LSB of work as dividend bits leave the MSB,
  // so after WIDTH steps work already holds the quotient.
  logic [WIDTH-1:0]   work;
  logic [DIGIT_W-1:0] rem_q;
  logic [5:0]         trial;
  logic               ge;

  // Trial remainder and the restoring compare against the base
  always_comb begin
    trial = {rem_q, work[WIDTH-1]};
    ge    = (trial >= 6'(BASE));
  end

  // Work/remainder registers; a new load wins over a step in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      rem_q <= '0;
    end else if (load) begin
      work  <= din;
      rem_q <= '0;
    end else if (step) begin
      rem_q <= ge ? DIGIT_W'(trial - 6'(BASE)) : trial[DIGIT_W-1:0];
      work  <= {work[WIDTH-2:0], ge};
    end else if (clr_rem) begin
      rem_q <= '0;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/kaktovik_scanner.sv
// rtl/kaktovik_scanner.sv - binary to base-20 converter with multiplexed Kaktovik digit scan
module kaktovik_scanner
  import kaktovik_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 18,
  parameter int PRESCALE = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              BLANKZ,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              E,
  output logic              RBI,
  output logic [DIGITS-1:0] SEL
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [63:0] OVF_LIMIT = pow_base(DIGITS);

  state_t state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [KW-1:0]      k;
  logic               ovf_pend;
  logic               done_q;
  logic               ovf_q;
  logic [DIGIT_W-1:0] rem;
  logic [DIGIT_W-1:0] dig  [DIGITS];
  logic [DIGIT_W-1:0] disp [DIGITS];
  logic               div_last, k_last, step, store, commit;

  logic [PW-1:0]      pcnt;
  logic [KW-1:0]      idx;
  logic [DIGITS-1:0]  sel_q;
  logic [DIGIT_W-1:0] dig_q;
  logic               rbi_q;
  logic               rbi_nxt;

  kaktovik_div20 #(.WIDTH(WIDTH)) u_div20 (
    .clk     (CLK),
    .rst     (RST),
    .load    (LOAD),
    .din     (DIN),
    .step    (step),
    .clr_rem (store),
    .rem     (rem)
  );

  // Next-state logic; LOAD restarts from any state, including the commit cycle
  always_comb begin
    state_nxt = state;
    div_last  = (cnt == CW'(WIDTH - 1));
    k_last    = (k == KW'(DIGITS - 1));
    step      = (state == DIV);
    store     = (state == STORE);
    commit    = store && k_last;
    case (state)
      IDLE:    state_nxt = IDLE;
      DIV:     if (div_last) state_nxt = STORE;
      STORE:   state_nxt = k_last ? IDLE : DIV;
      default: state_nxt = IDLE;
    endcase
    if (LOAD) state_nxt = DIV;
  end

  // FSM state, bit counter, digit index and overflow/done flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      ovf_pend <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= commit;
      if (commit) ovf_q <= ovf_pend;
      if (LOAD) begin
        cnt      <= '0;
        k        <= '0;
        ovf_pend <= (64'(DIN) >= OVF_LIMIT);
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end else if (store) begin
        cnt <= '0;
        if (!k_last) k <= k + KW'(1);
      end
    end
  end

  // Per-position scratch digits, written as each remainder completes
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DIGITS; i++) dig[i] <= '0;
    end else if (store) begin
      dig[k] <= rem;
    end
  end

  // Display registers change only at commit; the last digit comes straight from rem
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DIGITS; i++) disp[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < DIGITS; i++)
        disp[i] <= ovf_pend ? BLANK_CODE : ((KW'(i) == k) ? rem : dig[i]);
    end
  end

  // Ripple-blank: show a zero unless suppression is on and nothing above is nonzero
  always_comb begin
    rbi_nxt = !BLANKZ || (idx == '0);
    for (int i = 0; i < DIGITS; i++)
      if ((KW'(i) > idx) && (disp[i] != '0)) rbi_nxt = 1'b1;
  end

  // Free-running prescaler, MSD-first scan index and registered scan outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt  <= '0;
      idx   <= KW'(DIGITS - 1);
      sel_q <= DIGITS'(1) << (DIGITS - 1);
      dig_q <= '0;
      rbi_q <= 1'b0;
    end else begin
      if (pcnt == PW'(PRESCALE - 1)) begin
        pcnt <= '0;
        idx  <= (idx == '0) ? KW'(DIGITS - 1) : idx - KW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      sel_q <= DIGITS'(1) << idx;
      dig_q <= disp[idx];
      rbi_q <= rbi_nxt;
    end
  end

  assign BUSY            = (state != IDLE);
  assign DONE            = done_q;
  assign OVF             = ovf_q;
  assign {E, D, C, B, A} = dig_q;
  assign RBI             = rbi_q;
  assign SEL             = sel_q;

endmodule

// File: tb/tb_kaktovik_scanner.sv
// tb/tb_kaktovik_scanner.sv - scoreboard bench for kaktovik_scanner
module tb_kaktovik_scanner;

  localparam int ND = 4;
  localparam int NW = 18;
  localparam int PS = 4;
  localparam int LAT = ND * (NW + 1);

  logic CLK = 1'b0;
  logic RST, LOAD, BLANKZ;
  logic [NW-1:0] DIN;
  logic BUSY, DONE, OVF, A, B, C, D, E, RBI;
  logic [ND-1:0] SEL;

  typedef struct {
    logic [19:0] digs;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_committed;
  exp_t zero_e;
  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  kaktovik_scanner #(.DIGITS(ND), .WIDTH(NW), .PRESCALE(PS)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DIN(DIN), .BLANKZ(BLANKZ),
    .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
    .A(A), .B(B), .C(C), .D(D), .E(E), .RBI(RBI), .SEL(SEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (BUSY) busy_cnt++;
    if (DONE) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned din);
    exp_t e;
    int unsigned pw;
    logic [19:0] d;
    pw = 1;
    d = '0;
    for (int p = 0; p < ND; p++) begin
      d[p*5 +: 5] = 5'((din / pw) % 20);
      pw = pw * 20;
    end
    e.ovf = (din >= 160000);
    e.digs = e.ovf ? {4{5'd31}} : d;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    LOAD = 1'b0;
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_sel", SEL, 4'b1000);
    chk("rst_digit", {E, D, C, B, A}, 0);
    chk("rst_rbi", RBI, 0);
    RST = 1'b0;
    exp_q.delete();
    last_committed = zero_e;
  endtask

  // Called at a negedge; returns one negedge later with LOAD released
  task automatic start(input int unsigned din, input bit abandon);
    if (abandon && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model(din));
    LOAD = 1'b1;
    DIN = NW'(din);
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic scan_check(input exp_t e);
    int prev, run, changes, pos;
    logic [4:0] gd [ND];
    logic gr [ND];
    bit seen [ND];
    logic r;
    prev = -1; run = 0; changes = 0;
    for (int p = 0; p < ND; p++) begin gd[p] = '0; gr[p] = 1'b0; seen[p] = 1'b0; end
    for (int s = 0; s < 6 * PS; s++) begin
      @(negedge CLK);
      chk("sel_onehot", $onehot(SEL), 1);
      pos = 0;
      for (int p = 0; p < ND; p++) if (SEL[p]) pos = p;
      if (prev >= 0 && pos != prev) begin
        chk("scan_order", pos, (prev + ND - 1) % ND);
        if (changes > 0) chk("scan_hold", run, PS);
        changes++;
        run = 1;
      end else begin
        run++;
      end
      prev = pos;
      gd[pos] = {E, D, C, B, A};
      gr[pos] = RBI;
      seen[pos] = 1'b1;
    end
    for (int p = 0; p < ND; p++) begin
      r = !BLANKZ || (p == 0);
      for (int q = p + 1; q < ND; q++) if (e.digs[q*5 +: 5] != 0) r = 1'b1;
      chk($sformatf("seen_%0d", p), seen[p], 1);
      chk($sformatf("digit_%0d", p), gd[p], e.digs[p*5 +: 5]);
      chk($sformatf("rbi_%0d", p), gr[p], r);
    end
  endtask

  task automatic wait_done();
    exp_t e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      @(negedge CLK);
      if (DONE) begin got = 1'b1; break; end
    end
    if (!got || exp_q.size() == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("busy_len", busy_cnt, LAT);
    chk("done_count", done_cnt, 1);
    chk("ovf", OVF, e.ovf);
    @(negedge CLK);
    chk("done_pulse", DONE, 0);
    last_committed = e;
    scan_check(e);
  endtask

  initial begin
    RST = 1'b1; LOAD = 1'b0; DIN = '0; BLANKZ = 1'b1;
    zero_e.digs = '0;
    zero_e.ovf = 1'b0;
    last_committed = zero_e;
    do_reset();

    @(negedge CLK); start(0, 0); wait_done();
    @(negedge CLK); start(12345, 0); wait_done();
    @(negedge CLK); start(160000, 0); wait_done();

    // Restart at cycle 30: the first conversion is discarded, display holds
    @(negedge CLK); start(12345, 0);
    repeat (29) @(negedge CLK);
    start(19, 1);
    scan_check(last_committed);
    wait_done();

    // LOAD on the commit edge: commit lands and the next conversion starts
    @(negedge CLK); start(7, 0);
    repeat (LAT - 1) @(negedge CLK);
    start(300, 0);
    chk("ce_done", DONE, 1);
    chk("ce_busy", BUSY, 1);
    if (exp_q.size() > 0) last_committed = exp_q.pop_front();
    done_cnt = 0;
    scan_check(last_committed);
    wait_done();

    // Reset mid-conversion, then a fresh load
    @(negedge CLK); start(12345, 0);
    repeat (20) @(negedge CLK);
    do_reset();
    scan_check(zero_e);
    @(negedge CLK); start(20, 0); wait_done();

    BLANKZ = 1'b0;
    @(negedge CLK); start(5, 0); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kaktovik_scanner.md
KAKTOVIK_SCANNER -- requirements
Module: kaktovik_scanner

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of base-20 display positions.
REQ-002 Parameter WIDTH, default 18, SHALL set the width of the binary input DIN.
REQ-003 Parameter PRESCALE, default 1000, range 1 or more, SHALL set the clock cycles per digit scan slot.
REQ-004 Port CLK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port RST, input, 1: reset, synchronous and active-high.
REQ-006 Port LOAD, input, 1: start conversion of DIN.
REQ-007 Port DIN, input, WIDTH: unsigned binary value to display.
REQ-008 Port BLANKZ, input, 1: leading-zero suppression enable.
REQ-009 Port BUSY, output, 1: conversion in progress.
REQ-010 Port DONE, output, 1: one-cycle pulse marking the display-register update.
REQ-011 Port OVF, output, 1: the last loaded value was at least 20^DIGITS.
REQ-012 Ports A, B, C, D, E, output, 1 each: current digit, LSB to MSB, feeding the Kaktovik decoder value inputs.
REQ-013 Port RBI, output, 1: ripple-blank input for the decoder; 1 shows a zero glyph, 0 blanks a zero.
REQ-014 Port SEL, output, DIGITS: one-hot, active-high position enable; SEL[i] is position i, and 0 is least significant.

Function
REQ-015 The FSM SHALL have three states: IDLE, DIV and STORE.
REQ-016 LOAD sampled high in any state SHALL capture DIN into the work register, clear the remainder, set the digit index k to 0, set OVF_pending = (DIN >= 20^DIGITS) and enter DIV. A conversion in progress SHALL be abandoned.
REQ-017 In DIV, for WIDTH cycles, each cycle SHALL do a restoring step: rem' = {rem, work MSB}; if rem' >= 20, subtract 20 and shift 1 into the quotient, otherwise shift 0. rem SHALL be 6 bits wide internally and hold at most 19 after each step.
REQ-018 STORE, one cycle, SHALL write digit[k] = rem, set work = quotient, clear rem and increment k. It SHALL return to DIV if k < DIGITS-1; otherwise it SHALL commit.
REQ-019 Commit SHALL copy all digits into the display registers atomically. If OVF_pending is set, every display digit SHALL be 31 (the decoder blank code) and OVF SHALL be 1; otherwise OVF SHALL be 0.
REQ-020 Commit SHALL assert DONE for exactly one cycle and return to IDLE.
REQ-021 BUSY SHALL be 1 for exactly DIGITS*(WIDTH+1) cycles, starting on the edge that samples LOAD; it SHALL fall on the commit edge.
REQ-022 Conversion latency SHALL be fixed and independent of the value, including the overflow case.
REQ-023 The display registers SHALL keep their previous contents throughout a conversion.
REQ-024 The prescaler SHALL count 0 to PRESCALE-1 freely and wrap.
REQ-025 On each wrap, the scan index SHALL decrement from DIGITS-1 down to 0, then wrap back to DIGITS-1.
REQ-026 SEL, {E,D,C,B,A} and RBI SHALL be registered and change on the same edge.
REQ-027 {E,D,C,B,A} SHALL equal the display digit at the scan index.
REQ-028 RBI SHALL be 1 when BLANKZ=0, or when the index is 0, or when any more-significant display digit is nonzero; otherwise RBI SHALL be 0.
REQ-029 LOAD asserted on the commit edge SHALL be honoured: the commit completes and the new conversion starts.

Reset
REQ-030 RST SHALL force IDLE, clear work, rem, k and prescaler, and set every display digit to 0.
REQ-031 RST SHALL drive outputs to BUSY=0, DONE=0, OVF=0, A..E=0, RBI=0, and SEL one-hot at position DIGITS-1.
REQ-032 RST SHALL take priority over LOAD; a conversion in progress SHALL be discarded.

Structure
REQ-033 Package kaktovik_pkg SHALL hold BASE=20, the blank code 31, the digit width 5 and the FSM state enum.
REQ-034 The single sub-module kaktovik_div20 SHALL implement the restoring divide-by-20 step datapath (work, rem, quotient).

Verification
REQ-035 After reset, LOAD with DIN=0: BUSY high for 76 cycles, then DONE pulses once and digits are {0,0,0,0}. With BLANKZ=1, RBI=0 at positions 3 to 1 and RBI=1 at position 0.
REQ-036 LOAD with DIN=12345: after 76 cycles the digits MSD to LSD are {1,10,17,5} and OVF=0. With PRESCALE=4, SEL runs 1000, 0100, 0010, 0001, each held 4 cycles, with A..E matching.
REQ-037 LOAD with DIN=160000: after 76 cycles OVF=1 and all four scanned digits read 31.
REQ-038 LOAD with DIN=12345, then LOAD with DIN=19 at cycle 30: BUSY stays high 76 cycles from the second LOAD with no DONE in between. The display holds its prior value, then becomes {0,0,0,19}.
REQ-039 RST asserted mid-conversion: next cycle BUSY=0, all digits 0 and SEL at position 3; a later LOAD with DIN=20 yields {0,0,1,0}.
REQ-040 BLANKZ=0 with DIN=5: RBI=1 at every position.
